// File: rtl/adder_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one W-bit ripple adder time-shared over N limbs,
// least significant limb first, with the carry chained through a register.

module adder_v1 #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_ci,
    output logic [W-1:0] o_s,
    output logic         o_co
);
    logic [W:0] w_c;

    always_comb begin
        w_c    = '0;
        o_s    = '0;
        w_c[0] = i_ci;
        for (int unsigned i = 0; i < W; i++) begin
            o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
        o_co = w_c[W];
    end
endmodule

module adder_seq_ctrl #(
    parameter int unsigned W = 4,
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           sub,
    input  logic [W*N-1:0] a,
    input  logic [W*N-1:0] b,
    input  logic           cin,
    output logic           busy,
    output logic           done,
    output logic [W*N-1:0] sum,
    output logic           cout,
    output logic           ovf
);
    localparam int unsigned WN = W * N;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [WN-1:0]  r_a;
    logic [WN-1:0]  r_bx;
    logic [WN-1:0]  r_work;
    logic           r_carry;
    logic [KW-1:0]  r_k;
    logic [W-1:0]   w_s;
    logic           w_co;
    logic           w_last;
    logic [WN-1:0]  w_work_nxt;

    // b is stored already conditioned (~b for subtract), so the latched sub flag folds into r_bx
    adder_v1 #(.W(W)) u_adder (
        .i_a  (r_a[r_k*W +: W]),
        .i_b  (r_bx[r_k*W +: W]),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    assign w_last = (r_k == KW'(N - 1));

    always_comb begin
        w_work_nxt              = r_work;
        w_work_nxt[r_k*W +: W]  = w_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_bx    <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_bx    <= sub ? ~b : b;
                        r_carry <= sub ? ~cin : cin;
                        r_k     <= '0;
                    end
                end
                S_RUN: begin
                    r_work  <= w_work_nxt;
                    r_carry <= w_co;
                    r_k     <= r_k + KW'(1);
                    if (w_last) begin
                        sum  <= w_work_nxt;
                        cout <= w_co;
                        ovf  <= (r_a[WN-1] == r_bx[WN-1]) && (w_work_nxt[WN-1] != r_a[WN-1]);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Randomized self-checking bench for adder_seq_ctrl against a plain-arithmetic reference model.

module tb_adder_seq_ctrl;
    localparam int unsigned W  = 4;
    localparam int unsigned N  = 4;
    localparam int unsigned WN = W * N;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sub   = 1'b0;
    logic          cin   = 1'b0;
    logic [WN-1:0] a     = '0;
    logic [WN-1:0] b     = '0;
    logic          busy;
    logic          done;
    logic [WN-1:0] sum;
    logic          cout;
    logic          ovf;

    int            checks = 0;
    int            errors = 0;
    logic [WN-1:0] exp_sum_hold = '0;

    adder_seq_ctrl #(.W(W), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, cout, sum} from integer arithmetic on the whole operands.
    function automatic logic [WN+1:0] ref_op(input logic [WN-1:0] x, input logic [WN-1:0] y,
                                              input logic s, input logic c);
        longint m  = longint'(1) << WN;
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = x[WN-1] ? ux - m : ux;
        longint sy = y[WN-1] ? uy - m : uy;
        longint ci = c ? 1 : 0;
        longint r;
        longint sr;
        logic   co;
        logic   ov;
        if (!s) begin
            r  = ux + uy + ci;
            sr = sx + sy + ci;
            co = (r >= m);
        end else begin
            r  = ux - uy - ci;
            sr = sx - sy - ci;
            co = (r >= 0);
        end
        ov = (sr >= m / 2) || (sr < -(m / 2));
        return {ov, co, WN'(r & (m - 1))};
    endfunction

    task automatic run_op(input logic [WN-1:0] ia, input logic [WN-1:0] ib,
                          input logic isub, input logic icin);
        logic [WN+1:0] e;
        int            j;
        int            nbusy;
        bit            seen;
        e = ref_op(ia, ib, isub, icin);
        j = 0;
        while ((busy || done) && j < 20) begin
            @(posedge clk); #1;
            j++;
        end
        check("idle_wait", 64'(busy | done), 64'(0));
        a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = WN'($urandom); b = WN'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        nbusy = 0;
        seen  = 1'b0;
        for (j = 0; j < int'(N) + 6; j++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nbusy++;
            check("hold_sum", 64'(sum), 64'(exp_sum_hold));
            @(posedge clk); #1;
        end
        check("done_lat", seen ? 64'(j) : 64'(999), 64'(N));
        check("busy_cnt", 64'(nbusy), 64'(N));
        check("busy_w_done", 64'(busy), 64'(0));
        check("sum", 64'(sum), 64'(e[WN-1:0]));
        check("cout", 64'(cout), 64'(e[WN]));
        check("ovf", 64'(ovf), 64'(e[WN+1]));
        exp_sum_hold = e[WN-1:0];
        @(posedge clk); #1;
        check("done_pulse", 64'(done), 64'(0));
        check("sum_after", 64'(sum), 64'(exp_sum_hold));
    endtask

    initial begin
        logic [WN-1:0] opa [12];
        logic [WN-1:0] opb [12];
        logic [WN+1:0] e;

        #12;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_cout", 64'(cout), 64'(0));
        check("rst_ovf", 64'(ovf), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h1234, 16'h0234, 1'b1, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0);
        run_op(16'h0005, 16'h0002, 1'b1, 1'b1);

        // start held high: accepts at cycles 0 and 6, done after edges 4 and 10
        for (int i = 0; i < 12; i++) begin
            opa[i] = WN'($urandom);
            opb[i] = WN'($urandom);
        end
        sub = 1'b0; cin = 1'b0; start = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            a = opa[cyc];
            b = opb[cyc];
            @(posedge clk); #1;
            check("cont_done", 64'(done), 64'((cyc == 4) || (cyc == 10)));
            if (cyc == 4) begin
                e = ref_op(opa[0], opb[0], 1'b0, 1'b0);
                check("cont_sum0", 64'(sum), 64'(e[WN-1:0]));
            end
            if (cyc == 10) begin
                e = ref_op(opa[6], opb[6], 1'b0, 1'b0);
                check("cont_sum1", 64'(sum), 64'(e[WN-1:0]));
                exp_sum_hold = e[WN-1:0];
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("cont_idle", 64'(busy | done), 64'(0));

        // reset in RUN cycle 2 aborts the operation
        a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("mid_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_sum", 64'(sum), 64'(0));
        check("mid_rst_cout", 64'(cout), 64'(0));
        check("mid_rst_ovf", 64'(ovf), 64'(0));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("post_rst_quiet", 64'(busy | done), 64'(0));
        end
        exp_sum_hold = '0;
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            run_op(WN'($urandom), WN'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Multi-precision add/subtract sequencer.
- Computes a (W*N)-bit result by time-sharing one W-bit ripple adder instance (adder_v1, parameter W) over N limbs, least significant limb first.
- The carry is chained through a register, one limb per clock.
- Used wherever wide arithmetic is needed but a full-width adder is too costly; a simple start/done interface toward the issuing control logic.

Parameters:
- W, 4, limb width; passed to the internal adder.
- N, 4, number of limbs; operand width is W*N; N >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when idle.
- sub  input  1  0 = add, 1 = subtract; latched with start.
- a  input  W*N  operand A; latched with start.
- b  input  W*N  operand B; latched with start.
- cin  input  1  carry-in (add) or borrow-in (sub); latched with start.
- busy  output  1  high while limbs are being processed.
- done  output  1  one-cycle completion pulse.
- sum  output  W*N  result register.
- cout  output  1  carry-out of the top limb; for sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow of the whole operation.

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous, active-low.
- On reset assertion, immediately, regardless of state:
  - state = IDLE
  - busy = 0, done = 0, ovf = 0, cout = 0
  - sum = 0, internal operand/carry/limb-index registers = 0
- Reset mid-operation aborts the operation; no done is produced. The first start after deassertion behaves normally.
- FSM states:
  - IDLE -> RUN when start=1. Latch a, b, sub. Set carry register to (sub ? ~cin : cin). Clear limb index k to 0.
  - RUN: each cycle the adder computes limb k of a, plus limb k of b' (b' = sub ? ~b : b), plus the carry register. The adder sum is stored into working-result limb k, the adder carry-out into the carry register, and k increments. When k = N-1, go to DONE.
  - DONE: lasts one cycle, then -> IDLE unconditionally.
- Sign is the MSB of a, b' and the working result at bit W*N-1.
- Working result vs. result outputs:
  - The working result is separate from sum.
  - sum, cout and ovf load on the edge entering DONE; ovf = (sign a == sign b') AND (sign result != sign a).
  - They then hold until the next completion.
- Latency: start sampled at edge T gives:
  - busy = 1 for the N cycles after T;
  - done = 1 for exactly the cycle after that (cycle N+1 after T), with sum/cout/ovf valid in that same cycle.
  - done and busy are never high together.
- start while busy or in DONE is ignored, with no queuing. Back-to-back operation: start may be asserted in the DONE cycle but is not accepted; it is accepted in the following IDLE cycle. Throughput is therefore one operation per N+2 cycles.
- Operand inputs may change freely after acceptance; they have no effect until the next accepted start.
- Arithmetic is modulo 2^(W*N):
  - sub computes a - b - cin.
  - cout for sub is the inverted borrow.
- N = 1: a single RUN cycle; identical to one W-bit adder plus registered outputs.

Test Plan (W=4, N=4, cin=0 unless stated):
- add a=0x00FF, b=0x0001 -> done exactly 5 cycles after start edge, sum=0x0100, cout=0, ovf=0; busy high 4 cycles.
- add a=0xFFFF, b=0x0001, then separately a=0x7FFF, b=0x0001 -> first: sum=0x0000, cout=1, ovf=0; second: sum=0x8000, cout=0, ovf=1.
- sub a=0x1234, b=0x0234 -> sum=0x1000, cout=1; sub a=0x0000, b=0x0001 -> sum=0xFFFF, cout=0, ovf=0; sub a=0x0005, b=0x0002, cin=1 -> sum=0x0002, cout=1.
- start held high continuously with changing operands during busy -> only the first operands used; next op accepted in the cycle after done; done pulses spaced 6 cycles apart.
- rst_n low during RUN cycle 2 -> all outputs 0 immediately, no done; the next start completes correctly (e.g. 0x0F0F + 0x00F1 = 0x1000).
- random a/b/sub/cin, 1000 ops -> sum/cout/ovf match a reference model; sum stable between done pulses.
